// File: rtl/btn_debounce_pulse.sv
// Button debounce: accepts a level change only after a stable run of
// STABLE_CYCLES samples, then emits a one-cycle rise or fall pulse.
module btn_debounce_pulse #(
  parameter  int STABLE_CYCLES = 16,
  localparam int CNT_W = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse
);

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE_CHK,
    S_HIGH,
    S_FALL_CHK
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (sig_in) begin
          state_d = S_RISE_CHK;
          cnt_d   = ONE;
        end
      end
      S_RISE_CHK: begin
        // any low sample aborts the run; no partial credit
        if (!sig_in) begin
          state_d = S_LOW;
        end else if (cnt_q == LAST) begin
          state_d = S_HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_HIGH: begin
        if (!sig_in) begin
          state_d = S_FALL_CHK;
          cnt_d   = ONE;
        end
      end
      S_FALL_CHK: begin
        if (sig_in) begin
          state_d = S_HIGH;
        end else if (cnt_q == LAST) begin
          state_d = S_LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = S_LOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: directed vector table, corner sequences,
// and random bounce against a run-length reference model.
module tb_btn_debounce_pulse;

  localparam int SC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig_in = 1'b0;
  logic level, rise_pulse, fall_pulse;

  btn_debounce_pulse #(.STABLE_CYCLES(SC)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .level     (level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } exp_t;

  typedef struct packed {
    logic rst;
    logic sig;
    exp_t e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   stepn = 0;

  // reference: stable level plus length of the current disagreeing run
  logic m_lvl = 1'b0;
  int   m_run = 0;
  exp_t m_out;
  logic last_rise = 1'b0;

  task automatic model(input logic r, input logic s);
    m_out = '0;
    if (r) begin
      m_lvl = 1'b0;
      m_run = 0;
    end else if (s != m_lvl) begin
      m_run++;
      if (m_run == SC) begin
        m_lvl = s;
        m_run = 0;
        m_out.rise = s;
        m_out.fall = ~s;
      end
    end else begin
      m_run = 0;
    end
    m_out.level = m_lvl;
  endtask

  task automatic step(input logic r, input logic s, input logic use_m,
                      input exp_t e, input string nm);
    exp_t want;
    @(negedge clk);
    rst = r;
    sig_in = s;
    model(r, s);
    sb.push_back(use_m ? m_out : e);
    @(posedge clk);
    #1;
    stepn++;
    want = sb.pop_front();
    tests++;
    if ({level, rise_pulse, fall_pulse} !== want) begin
      fails++;
      $display("FAIL %s step %0d: got level=%b rise=%b fall=%b, want %b %b %b",
               nm, stepn, level, rise_pulse, fall_pulse,
               want.level, want.rise, want.fall);
    end
    if (use_m) begin
      if (r) last_rise = 1'b0;
      if (rise_pulse && fall_pulse) begin
        tests++;
        fails++;
        $display("FAIL both_pulses step %0d: rise=1 fall=1, want one", stepn);
      end else if (rise_pulse || fall_pulse) begin
        tests++;
        if (rise_pulse == last_rise) begin
          fails++;
          $display("FAIL alternate step %0d: rise=%b fall=%b, last_rise=%b",
                   stepn, rise_pulse, fall_pulse, last_rise);
        end
        last_rise = rise_pulse;
      end
    end
  endtask

  task automatic add(input logic r, input logic s,
                     input logic l, input logic ri, input logic f);
    vec_t v;
    v.rst = r;
    v.sig = s;
    v.e = '{level: l, rise: ri, fall: f};
    vecs.push_back(v);
  endtask

  exp_t z = '0;

  initial begin
    // reset
    add(1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0);
    // clean rise: accepted on the 4th high sample
    add(0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0);
    add(0, 1, 1, 1, 0);
    add(0, 1, 1, 0, 0);
    add(0, 1, 1, 0, 0);
    // 3-cycle low glitch rejected
    add(0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0);
    add(0, 1, 1, 0, 0);
    // clean fall
    add(0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0);
    // bounce: high 3, low 1, high 3, low 1 -> nothing
    for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0);
    // then high 4 -> one rise
    for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 0);
    add(0, 1, 1, 1, 0);
    add(0, 1, 1, 0, 0);
    // back low
    for (int k = 0; k < 3; k++) add(0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0);

    step(1, 0, 0, vecs[0].e, "reset0");
    step(1, 0, 0, vecs[1].e, "reset1");
    for (int i = 0; i < 20; i++) step(0, 0, 0, z, "idle");
    for (int i = 2; i < vecs.size(); i++)
      step(vecs[i].rst, vecs[i].sig, 0, vecs[i].e, "vec");

    // reset in the middle of a rise check discards the run
    step(0, 1, 0, '{0, 0, 0}, "rmid_pre");
    step(0, 1, 0, '{0, 0, 0}, "rmid_pre");
    step(1, 1, 0, '{0, 0, 0}, "rmid_rst");
    step(0, 1, 0, '{0, 0, 0}, "rmid_post");
    step(0, 1, 0, '{0, 0, 0}, "rmid_post");
    step(0, 1, 0, '{0, 0, 0}, "rmid_post");
    step(0, 1, 0, '{1, 1, 0}, "rmid_rise");
    step(0, 1, 0, '{1, 0, 0}, "rmid_hold");
    last_rise = 1'b1;

    // random bounce against the reference model
    begin
      int n = 0;
      while (n < 10000) begin
        logic v = 1'($urandom_range(0, 1));
        int len = $urandom_range(1, 6);
        for (int j = 0; j < len && n < 10000; j++) begin
          logic r = ($urandom_range(0, 499) == 0);
          step(r, v, 1, z, "rand");
          n++;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
